// File: rtl/cacheline_adaptor.sv
// Cache-line <-> memory-burst adaptor: a full-line read/write becomes BEATS narrow beats, beat 0 least significant.
// Latency: BEATS+2 cycles request-to-resp with no gaps; beat gaps (burst_resp_i=0) simply stall the counter.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   line_read_i,
    input  logic                   line_write_i,
    input  logic [ADDR_WIDTH-1:0]  line_addr_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   line_resp_o,
    output logic                   burst_read_o,
    output logic                   burst_write_o,
    output logic [ADDR_WIDTH-1:0]  burst_addr_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   burst_resp_i
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         count;
    logic [LINE_WIDTH-1:0] wbuf;
    logic [LINE_WIDTH-1:0] line_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_beat;

    assign last_beat = burst_resp_i && (count == CW'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            wbuf   <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write has priority when both requests arrive together.
                    if (line_write_i) begin
                        wbuf   <= line_i;
                        addr_q <= line_addr_i & ALIGN_MASK;
                        state  <= WRITE;
                    end else if (line_read_i) begin
                        addr_q <= line_addr_i & ALIGN_MASK;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (burst_resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (count == CW'(b))
                                line_q[b*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        end
                        if (last_beat) begin
                            count <= '0;
                            state <= DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (burst_resp_i) begin
                        if (last_beat) begin
                            count <= '0;
                            state <= DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                DONE: begin
                    addr_q <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        burst_o = '0;
        if (state == WRITE) begin
            for (int b = 0; b < BEATS; b++) begin
                if (count == CW'(b))
                    burst_o = wbuf[b*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    assign burst_read_o  = (state == READ);
    assign burst_write_o = (state == WRITE);
    assign line_resp_o   = (state == DONE);
    assign burst_addr_o  = addr_q;
    assign line_o        = line_q;

endmodule
